// File: rtl/alu_result_uart_tx.sv
// UART transmitter for ALU result bytes: valid/ready capture, 8N1 serialisation, LSB first.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit (8E1).
module alu_result_uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       result_valid,
    input  logic [7:0] result,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("alu_result_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    // Handshake: a byte is taken on any posedge where result_valid && ready;
    // ready depends only on the state register, never on result_valid.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, cnt_next;
    logic [2:0]       bit_idx, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             parity_bit, parity_next;
    logic             tx_next, busy_next, overrun_next;
    logic             bit_done;

    assign ready    = (state == S_IDLE);
    assign bit_done = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= cnt_next;
            bit_idx    <= idx_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            tx         <= tx_next;
            busy       <= busy_next;
            overrun    <= overrun_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = baud_cnt;
        idx_next    = bit_idx;
        shift_next  = shift_reg;
        parity_next = parity_bit;

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (result_valid) begin
                    state_next  = S_START;
                    shift_next  = result;
                    parity_next = ^result;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_next = S_DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    idx_next   = bit_idx + 3'd1;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_next = S_STOP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Line level is registered from the next state so tx and state change on the same edge.
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = parity_next;
            default:  tx_next = 1'b1;
        endcase

        busy_next    = (state_next != S_IDLE);
        overrun_next = result_valid && !ready;
    end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx at CLKS_PER_BIT=10: line waveform, handshake, overrun and reset checks.
module tb_alu_result_uart_tx;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int CPB      = 10;
`ifdef UART_PARITY_EN
    localparam int  NBITS = 11;
    localparam bit  PAR   = 1'b1;
`else
    localparam int  NBITS = 10;
    localparam bit  PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       result_valid = 1'b0;
    logic [7:0] result = 8'd0;
    logic       ready, tx, busy, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Captured {tx, ready, busy, overrun} per cycle after the accept edge.
    logic [3:0] obs_v[0:511];
    logic [7:0] exp_q[$];

    alu_result_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .result_valid (result_valid),
        .result       (result),
        .ready        (ready),
        .tx           (tx),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Reference: the n-th bit slot of a UART frame carrying byte b.
    function automatic logic line_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (PAR && n == 9) return ^b;
        return 1'b1;
    endfunction

    // Expected {tx, ready, busy, overrun} j cycles into a frame (j >= FRAME: idle line).
    function automatic logic [3:0] frame_vec(input logic [7:0] b, input int j);
        if (j < FRAME) return {line_bit(b, j / CPB), 1'b0, 1'b1, 1'b0};
        return 4'b1100;
    endfunction

    // Offers byte b with the bench sitting in an idle cycle, then records ncyc cycles.
    task automatic run_frame(input logic [7:0] b, input int ncyc, input bit hold,
                             input int inj_k, input logic [7:0] inj_b, input int rst_k);
        result       = b;
        result_valid = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            obs_v[k] = {tx, ready, busy, overrun};
            reset_n  = 1'b1;
            if (!hold) begin
                result_valid = 1'b0;
                result       = 8'($urandom_range(0, 255));
            end
            if (k == inj_k) begin
                result_valid = 1'b1;
                result       = inj_b;
            end
            if (k == rst_k) reset_n = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (tx !== 1'b1)      begin n_bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        n_cmp++; if (ready !== 1'b1)   begin n_bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({tx, ready, busy, overrun} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_release_idle got=%b exp=1100", {tx, ready, busy, overrun});
        end
    endtask

    task automatic test_known_patterns();
        logic [7:0] pats[4];
        pats = '{8'hA5, 8'hFE, 8'h00, 8'hFF};
        for (int p = 0; p < 4; p++) begin
            run_frame(pats[p], FRAME + 1, 1'b0, -1, 8'h00, -1);
            for (int k = 0; k <= FRAME; k++) begin
                n_cmp++;
                if (obs_v[k] !== frame_vec(pats[p], k)) begin
                    n_bad++;
                    $display("FAIL pattern_%h cycle=%0d got=%b exp=%b", pats[p], k + 1, obs_v[k],
                             frame_vec(pats[p], k));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b, got, exp_b;
        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            run_frame(b, FRAME + 1, 1'b0, -1, 8'h00, -1);
            for (int k = 0; k <= FRAME; k++) begin
                n_cmp++;
                if (obs_v[k] !== frame_vec(b, k)) begin
                    n_bad++;
                    $display("FAIL random_%h cycle=%0d got=%b exp=%b", b, k + 1, obs_v[k],
                             frame_vec(b, k));
                end
            end
            // Receiver-style decode at mid-bit of each data slot.
            for (int n = 0; n < 8; n++) got[n] = obs_v[(n + 1) * CPB + CPB / 2][3];
            exp_b = exp_q.pop_front();
            n_cmp++;
            if (got !== exp_b) begin
                n_bad++;
                $display("FAIL random_decode got=%h exp=%h", got, exp_b);
            end
        end
    endtask

    task automatic test_overrun();
        logic [3:0] e;
        run_frame(8'h0F, FRAME + 21, 1'b0, 24, 8'h33, -1);
        for (int k = 0; k < FRAME + 21; k++) begin
            e = frame_vec(8'h0F, k);
            if (k == 25) e[0] = 1'b1;
            n_cmp++;
            if (obs_v[k] !== e) begin
                n_bad++;
                $display("FAIL overrun cycle=%0d got=%b exp=%b", k + 1, obs_v[k], e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        run_frame(b, 41, 1'b0, -1, 8'h00, 39);
        for (int k = 0; k < 40; k++) begin
            n_cmp++;
            if (obs_v[k] !== frame_vec(b, k)) begin
                n_bad++;
                $display("FAIL reset_mid_pre cycle=%0d got=%b exp=%b", k + 1, obs_v[k], frame_vec(b, k));
            end
        end
        n_cmp++;
        if (obs_v[40] !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_mid_abort got=%b exp=1100", obs_v[40]);
        end
        run_frame(8'h01, FRAME + 1, 1'b0, -1, 8'h00, -1);
        for (int k = 0; k <= FRAME; k++) begin
            n_cmp++;
            if (obs_v[k] !== frame_vec(8'h01, k)) begin
                n_bad++;
                $display("FAIL reset_mid_after cycle=%0d got=%b exp=%b", k + 1, obs_v[k],
                         frame_vec(8'h01, k));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        int ncyc;
        ncyc = 3 * (FRAME + 1);
        run_frame(8'h3C, ncyc, 1'b1, -1, 8'h00, -1);
        result_valid = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            e = frame_vec(8'h3C, k % (FRAME + 1));
            e[0] = (k >= 1) && (((k - 1) % (FRAME + 1)) < FRAME);
            n_cmp++;
            if (obs_v[k] !== e) begin
                n_bad++;
                $display("FAIL back_to_back cycle=%0d got=%b exp=%b", k + 1, obs_v[k], e);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx, ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL back_to_back_end got=%b exp=110", {tx, ready, busy});
        end
    endtask

    initial begin
        test_reset();
        test_known_patterns();
        test_random();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
